dp_dcram: RTL and testbench
===========================

DP_DCRAM -- requirements
Module: dp_dcram

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: ports wr_clk and areset_n.
REQ-002 Parameter DWIDTH, default 8, data word width in bits.
REQ-003 Parameter AWIDTH, default 6, address width; depth DEPTH = 2^AWIDTH words (64 by default).
REQ-004 wr_clk  input  1  sole clock, rising-edge; drives both the write port and the read port.
REQ-005 areset_n  input  1  asynchronous active-low reset.
REQ-006 addr0  input  AWIDTH  write-port address.
REQ-007 data0  input  DWIDTH  write-port data.
REQ-008 we0  input  1  write enable, active high.
REQ-009 addr1  input  AWIDTH  read-port address.
REQ-010 re1  input  1  read enable, active high.
REQ-011 q1  output  DWIDTH  registered read data.
REQ-012 q1_valid  output  1  high for the cycle in which q1 carries data from a read issued on the previous edge.

Function
REQ-013 Storage SHALL be a DEPTH x DWIDTH array; both ports address it with plain binary addresses, full range 0..DEPTH-1, no wrap logic inside the block.
REQ-014 Write: on a rising wr_clk edge with we0=1 and areset_n=1, mem[addr0] SHALL take data0; with we0=0 memory is unchanged.
REQ-015 Read: on a rising wr_clk edge with re1=1, q1 SHALL load mem[addr1]; latency is exactly one clock from the edge sampling re1.
REQ-016 With re1=0, q1 SHALL hold its previous value.
REQ-017 q1_valid SHALL be registered: 1 after an edge with re1=1, 0 after an edge with re1=0.
REQ-018 Read and write on the same edge to different addresses SHALL both complete independently.
REQ-019 Read and write on the same edge to the same address (we0=1, re1=1, addr0=addr1) SHALL be write-first: q1 takes data0, and memory also takes data0.
REQ-020 Writes to the same address on consecutive edges SHALL leave the last value written; no write is dropped at any address, including 0 and DEPTH-1.
REQ-021 we0 and re1 SHALL have no restrictions on simultaneous or back-to-back assertion; one read and one write are accepted every cycle.
REQ-022 Read data SHALL never depend on data0 except in the same-address collision of REQ-019.

Reset
REQ-023 While areset_n=0, independent of wr_clk, q1 SHALL be 0 and q1_valid SHALL be 0.
REQ-024 While areset_n=0, writes SHALL be ignored.
REQ-025 Memory contents SHALL NOT be cleared by reset; a location never written reads as undefined (X in simulation).
REQ-026 Reset asserted mid-operation SHALL clear q1 and q1_valid immediately; contents written before reset SHALL remain readable after release.
REQ-027 After areset_n rises, the first rising edge SHALL already accept reads and writes.

Verification
REQ-028 Reset, then write 0xA5 to address 3, then next cycle read address 3 -> one edge after the read, q1=0xA5 and q1_valid=1.
REQ-029 Write mem[i]=i for i=0..63 on consecutive edges, then read 0..63 back to back -> q1 sequence 0x00..0x3F, one per cycle, with q1_valid held at 1.
REQ-030 Same edge: we0=1, addr0=5, data0=0x3C; re1=1, addr1=5 (old content 0x11) -> q1=0x3C; a later read of address 5 also returns 0x3C.
REQ-031 Read address 7 (content 0x42), then hold re1=0 for 3 cycles while writing 0x99 to address 7 -> q1 stays 0x42 and q1_valid=0 during the hold cycles.
REQ-032 Write 0x5A to address 63 and read it (q1=0x5A), then pulse areset_n low between clock edges -> q1=0 and q1_valid=0 at once; after release, a read of address 63 returns 0x5A.
REQ-033 Hold areset_n=0 and write 0xFF to address 0 (old 0x00) -> after release, a read of address 0 returns 0x00.

Source files
------------

// File: rtl/dp_dcram.sv
// Single-clock dual-port RAM: one write port, one registered read port.
// Same-address read/write collisions return the incoming write data.
module dp_dcram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
) (
  input  logic              wr_clk,
  input  logic              areset_n,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] data0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic              re1,
  output logic [DWIDTH-1:0] q1,
  output logic              q1_valid
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              wr_en;
  logic              hit;
  logic [DWIDTH-1:0] rd_data;
  logic [DWIDTH-1:0] q1_d, q1_q;
  logic              vld_d, vld_q;

  assign wr_en = we0 && areset_n;
  assign hit   = wr_en && (addr0 == addr1);

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[addr0] <= data0;
    end
  end

  always_comb begin
    rd_data = mem[addr1];
    if (hit) begin
      rd_data = data0;
    end
  end

  always_comb begin
    q1_d  = q1_q;
    vld_d = 1'b0;
    if (re1) begin
      q1_d  = rd_data;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge wr_clk or negedge areset_n) begin
    if (!areset_n) begin
      q1_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      q1_q  <= q1_d;
      vld_q <= vld_d;
    end
  end

  assign q1       = q1_q;
  assign q1_valid = vld_q;

endmodule

// File: tb/tb_dp_dcram.sv
// Directed bench for dp_dcram.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_dp_dcram;

  logic       wr_clk;
  logic       areset_n;
  logic [5:0] addr0;
  logic [7:0] data0;
  logic       we0;
  logic [5:0] addr1;
  logic       re1;
  logic [7:0] q1;
  logic       q1_valid;

  int n_cmp;
  int n_bad;

  dp_dcram #(
    .DWIDTH(8),
    .AWIDTH(6)
  ) dut (
    .wr_clk  (wr_clk),
    .areset_n(areset_n),
    .addr0   (addr0),
    .data0   (data0),
    .we0     (we0),
    .addr1   (addr1),
    .re1     (re1),
    .q1      (q1),
    .q1_valid(q1_valid)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0;
    re1 = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    we0   = 1'b1;
    addr0 = a;
    data0 = d;
    re1   = 1'b0;
    tick();
    we0 = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e,
                    input string tag);
    we0   = 1'b0;
    re1   = 1'b1;
    addr1 = a;
    tick();
    re1 = 1'b0;
    chk({tag, "_q"}, 32'(q1), 32'(e));
    chk({tag, "_v"}, 32'(q1_valid), 32'd1);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    areset_n = 1'b0;
    addr0    = '0;
    data0    = '0;
    addr1    = '0;
    idle();
    #1;
    chk("rst_q0", 32'(q1), 32'h0);
    chk("rst_v0", 32'(q1_valid), 32'h0);
    tick();
    tick();
    chk("rst_q", 32'(q1), 32'h0);
    chk("rst_v", 32'(q1_valid), 32'h0);
    areset_n = 1'b1;

    // basic write then read
    wr(6'd3, 8'hA5);
    chk("wr_only_v", 32'(q1_valid), 32'h0);
    rd(6'd3, 8'hA5, "a5");

    // fill and stream back
    for (int i = 0; i < 64; i++) begin
      wr(6'(i), 8'(i));
    end
    we0 = 1'b0;
    re1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      addr1 = 6'(i);
      tick();
      chk("strm_q", 32'(q1), 32'(i));
      chk("strm_v", 32'(q1_valid), 32'd1);
    end
    idle();
    tick();
    chk("strm_end_v", 32'(q1_valid), 32'h0);
    chk("strm_hold_q", 32'(q1), 32'h3F);

    // same-address collision is write-first
    wr(6'd5, 8'h11);
    we0   = 1'b1;
    addr0 = 6'd5;
    data0 = 8'h3C;
    re1   = 1'b1;
    addr1 = 6'd5;
    tick();
    idle();
    chk("coll_q", 32'(q1), 32'h3C);
    chk("coll_v", 32'(q1_valid), 32'h1);
    rd(6'd5, 8'h3C, "coll_mem");

    // different addresses on one edge
    we0   = 1'b1;
    addr0 = 6'd10;
    data0 = 8'h77;
    re1   = 1'b1;
    addr1 = 6'd11;
    tick();
    idle();
    chk("diff_q", 32'(q1), 32'h0B);
    rd(6'd10, 8'h77, "diff_mem");

    // hold q1 while writing under it
    wr(6'd7, 8'h42);
    rd(6'd7, 8'h42, "hold_rd");
    for (int i = 0; i < 3; i++) begin
      we0   = 1'b1;
      addr0 = 6'd7;
      data0 = 8'h99;
      re1   = 1'b0;
      tick();
      chk("hold_q", 32'(q1), 32'h42);
      chk("hold_v", 32'(q1_valid), 32'h0);
    end
    idle();
    rd(6'd7, 8'h99, "hold_mem");

    // back-to-back writes, last one wins, at both ends
    wr(6'd0, 8'h01);
    wr(6'd0, 8'h02);
    rd(6'd0, 8'h02, "b2b_lo");
    wr(6'd63, 8'hC1);
    wr(6'd63, 8'h5A);
    rd(6'd63, 8'h5A, "b2b_hi");

    // mid-cycle reset pulse
    idle();
    #2;
    areset_n = 1'b0;
    #1;
    chk("pulse_q", 32'(q1), 32'h0);
    chk("pulse_v", 32'(q1_valid), 32'h0);
    #1;
    areset_n = 1'b1;
    tick();
    rd(6'd63, 8'h5A, "post_pulse");

    // writes ignored during reset
    wr(6'd0, 8'h00);
    areset_n = 1'b0;
    we0   = 1'b1;
    addr0 = 6'd0;
    data0 = 8'hFF;
    tick();
    tick();
    chk("rst_wr_q", 32'(q1), 32'h0);
    areset_n = 1'b1;
    rd(6'd0, 8'h00, "rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
